// File: rtl/io_request_arbiter.sv
// io_request_arbiter
// Shares one non-cacheable IO bus between NUM_CORES pipelines. Requests are
// granted round-robin with a single transaction outstanding at a time. Each
// transaction ends with a one-cycle done pulse to its core. A watchdog
// aborts transactions the device never accepts or answers.
//
// Handshake: the device takes a command in any cycle where bus_read_en or
// bus_write_en is high together with bus_ready. A read response is taken in
// the first WAIT_RESP cycle with bus_read_valid high. A core holds its
// enable until its core_done pulse and drops it in the next cycle.

module io_request_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CORES-1:0]    core_read_en,
   input  logic [NUM_CORES-1:0]    core_write_en,
   input  logic [NUM_CORES*32-1:0] core_address,
   input  logic [NUM_CORES*32-1:0] core_write_data,
   output logic [NUM_CORES-1:0]    core_done,
   output logic [31:0]             core_read_data,
   output logic                   core_error,
   output logic                   bus_read_en,
   output logic                   bus_write_en,
   output logic [31:0]             bus_address,
   output logic [31:0]             bus_write_data,
   input  logic                   bus_ready,
   input  logic [31:0]             bus_read_data,
   input  logic                   bus_read_valid,
   output logic                   busy
);

   localparam int PW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TW     = (TW_RAW > 10) ? TW_RAW : 10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [NUM_CORES-1:0] req;
   logic [31:0]          addr_arr  [NUM_CORES];
   logic [31:0]          wdata_arr [NUM_CORES];

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_idx;
   logic          grant_valid;
   logic [PW:0]   arb_sum;
   logic [PW-1:0] arb_idx;
   logic [PW-1:0] rr_nxt;

   logic [PW-1:0] gnt_q;
   logic          is_write_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [TW-1:0] timer;

   logic expired;
   logic resp_take;
   logic timeout_hit;

   assign req = core_read_en | core_write_en;

   // Unpack the per-core address and data buses into indexable arrays.
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = core_address[32*gi +: 32];
      assign wdata_arr[gi] = core_write_data[32*gi +: 32];
   end

   assign expired = (timer == TW'(TIMEOUT_CYCLES - 1));

   // Round-robin search: first requester at or after rr_ptr, wrapping around.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      arb_sum     = '0;
      arb_idx     = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         arb_sum = {1'b0, rr_ptr} + (PW+1)'(i);
         if (arb_sum >= (PW+1)'(NUM_CORES)) begin
            arb_sum = arb_sum - (PW+1)'(NUM_CORES);
         end
         arb_idx = arb_sum[PW-1:0];
         if (!grant_valid && req[arb_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = arb_idx;
         end
      end
      rr_nxt = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + PW'(1);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an accept or response beats a simultaneous expiry.
   always_comb begin
      state_nxt   = state;
      resp_take   = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (bus_ready) begin
               state_nxt = is_write_q ? DONE : WAIT_RESP;
            end else if (expired) begin
               state_nxt   = DONE;
               timeout_hit = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (bus_read_valid) begin
               state_nxt = DONE;
               resp_take = 1'b1;
            end else if (expired) begin
               state_nxt   = DONE;
               timeout_hit = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction registers: latched on grant, updated while the bus is in use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         gnt_q      <= '0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         timer      <= '0;
      end else begin
         if (state == IDLE && grant_valid) begin
            rr_ptr     <= rr_nxt;
            gnt_q      <= grant_idx;
            is_write_q <= core_write_en[grant_idx];
            addr_q     <= addr_arr[grant_idx];
            wdata_q    <= wdata_arr[grant_idx];
            rdata_q    <= '0;
            err_q      <= 1'b0;
            timer      <= '0;
         end else if (state == ISSUE || state == WAIT_RESP) begin
            timer <= timer + TW'(1);
            if (resp_take) begin
               rdata_q <= bus_read_data;
            end
            if (timeout_hit) begin
               rdata_q <= 32'hFFFF_FFFF;
               err_q   <= 1'b1;
            end
         end
      end
   end

   // Outputs are decodes of registered state and latched transaction fields.
   always_comb begin
      bus_read_en    = (state == ISSUE) && !is_write_q;
      bus_write_en   = (state == ISSUE) && is_write_q;
      bus_address    = addr_q;
      bus_write_data = wdata_q;
      busy           = (state != IDLE);
      core_done      = '0;
      core_read_data = '0;
      core_error     = 1'b0;
      if (state == DONE) begin
         core_done[gnt_q] = 1'b1;
         core_read_data   = rdata_q;
         core_error       = err_q;
      end
   end

endmodule

// File: doc/io_request_arbiter.md
# io_request_arbiter

Shares the single non-cacheable IO bus between the `io_*` ports of NUM_CORES instruction pipelines. Requests are arbitrated round-robin, and exactly one transaction is outstanding on the bus at a time. The block completes each request with a one-cycle done pulse back to its core. A watchdog terminates a transaction that the IO device never answers. The block sits at the top level, between the per-core pipelines and the IO device fabric.

## Interface
Parameters:
- NUM_CORES, 4: number of requesting cores; minimum 2.
- TIMEOUT_CYCLES, 1023: cycles spent in ISSUE plus WAIT_RESP before a transaction is aborted; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- core_read_en  in  NUM_CORES  per-core read request; held until that core's done
- core_write_en  in  NUM_CORES  per-core write request; held until done
- core_address  in  NUM_CORES*32  core i address at bits [32i+31:32i]
- core_write_data  in  NUM_CORES*32  core i store data, same packing
- core_done  out  NUM_CORES  one-hot, one-cycle completion pulse
- core_read_data  out  32  read result; valid while core_done != 0
- core_error  out  1  set with core_done when the transaction timed out
- bus_read_en  out  1  IO read command
- bus_write_en  out  1  IO write command
- bus_address  out  32  IO address
- bus_write_data  out  32  IO store data
- bus_ready  in  1  device accepts the command in any cycle where bus_*_en and bus_ready are both 1
- bus_read_data  in  32  read response data
- bus_read_valid  in  1  read response strobe
- busy  out  1  high in every state except IDLE

## Operation
- Request from core i = core_read_en[i] | core_write_en[i]. If both bits are set, the request is a write.
- Round-robin pointer rr_ptr (reset value 0). In IDLE, the lowest requesting index ≥ rr_ptr wins; if none, the search wraps to the lowest requesting index below rr_ptr. On a grant to core g, rr_ptr <= (g+1) mod NUM_CORES.
- On a grant, the block latches g, the operation type, the address and the write data into internal registers. Bus outputs are driven only from these latched registers.
- State machine:
  - IDLE: if any request is present, grant and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive bus_read_en or bus_write_en. If bus_ready is 1, a write goes to DONE and a read goes to WAIT_RESP. If the timer expires first, go to DONE with error.
  - WAIT_RESP: on bus_read_valid, latch bus_read_data and go to DONE. On timer expiry, go to DONE with error.
  - DONE: core_done[g] = 1 and core_error = error flag; return to IDLE.
- Timer: 10-bit-minimum counter, sized as $clog2(TIMEOUT_CYCLES+1). Cleared on grant; incremented in every ISSUE and WAIT_RESP cycle. Expiry is reached when the count equals TIMEOUT_CYCLES - 1 in a cycle with no accept and no response.
- On timeout: core_read_data = 32'hFFFFFFFF and core_error = 1. For a write that times out, the write is dropped.
- bus_read_valid outside WAIT_RESP is ignored. Stale late responses are a system-level error and are not filtered.
- Outputs in IDLE and DONE: bus_read_en = 0 and bus_write_en = 0.
- core_read_data is 0 except during the DONE cycle.
- Requesters must deassert en in the cycle after their done pulse. In DONE the block ignores all requests; IDLE re-arbitrates from the next cycle on.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, timer 0, latched registers 0. Reset asserted mid-transaction aborts immediately, with no done pulse. The device must tolerate an abandoned command.
- Cycle numbering for the minimum write latency: the request is visible in cycle 0 and the grant is taken at the end of cycle 0.
  - ISSUE is in cycle 1; with bus_ready = 1 the command is accepted in cycle 1.
  - core_done is in cycle 2, and the block is back in IDLE in cycle 3.
  - Throughput: one write per 3 cycles.
- Minimum read latency: bus_read_valid in cycle 2 (the first WAIT_RESP cycle) gives done in cycle 3.
- Bus command outputs are registered state decodes. No combinational path exists from core_* inputs to bus_* outputs.
- bus_ready and bus_read_valid only affect state at the next edge; no combinational path exists to core_done.
- The granted core's address and data may change after the grant without affecting the bus.

## Test plan
- Single write, core 2, addr 0x0000_0100, data 0xA5A5_5A5A, bus_ready tied 1: bus_write_en is high exactly in cycle 1 with these values; core_done = 4'b0100 in cycle 2; core_error = 0.
- Read, core 0, with bus_read_valid 5 cycles after accept and data 0x1234_5678: core_read_data = 0x1234_5678 on the done cycle; busy is high from cycle 1 through done.
- All 4 cores request writes continuously from reset: grant order is 0,1,2,3,0 and each core gets exactly one done per 12 cycles.
- Read with bus_ready = 0 forever and TIMEOUT_CYCLES = 8: done arrives 8 cycles after ISSUE entry, with core_error = 1 and core_read_data = 0xFFFFFFFF.
- Reset pulsed during WAIT_RESP: all outputs are 0 on the next sample, no core_done is seen, and the next request from core 3 is granted with rr_ptr = 0 (core 0 is preferred if it requests simultaneously).
- A stray bus_read_valid in IDLE, followed by a normal write: no done is generated by the stray strobe, and the write completes normally.
